// File: rtl/seg_bin2bcd_encoder_if.sv
// Handshake and display bus between a value producer and seg_bin2bcd_encoder.
interface seg_bin2bcd_encoder_if #(
  parameter int unsigned BIN_W = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [BIN_W-1:0] in_value;
  logic             done;
  logic             overflow;
  logic [7:0]       seg_data_0;
  logic [7:0]       seg_data_1;
  logic [7:0]       seg_data_2;
  logic [7:0]       seg_data_3;
  logic [7:0]       seg_data_4;
  logic [7:0]       seg_data_5;

  modport master (
    output in_valid, in_value,
    input  in_ready, done, overflow,
    input  seg_data_0, seg_data_1, seg_data_2, seg_data_3, seg_data_4, seg_data_5
  );

  modport slave (
    input  in_valid, in_value,
    output in_ready, done, overflow,
    output seg_data_0, seg_data_1, seg_data_2, seg_data_3, seg_data_4, seg_data_5
  );
endinterface

// File: rtl/seg_bin2bcd_encoder.sv
// Binary to 6-digit seven-segment encoder: sequential double-dabble, then
// active-low segment decode with optional decimal points.
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN (blank leading zero digits).
module seg_bin2bcd_encoder #(
  parameter int unsigned BIN_W   = 20,
  parameter logic [5:0]  DP_MASK = 6'b000000
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_bin2bcd_encoder_if.slave  bus
);

  localparam int unsigned NDIG     = 6;
  localparam int unsigned BCD_W    = 24;
  localparam int unsigned ITER_W   = $clog2(BIN_W + 1);
  localparam logic [31:0] MAX_DISP = 32'd999999;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Highest digit carrying a decimal point; digits at or below it are never blanked.
  function automatic int dp_high(input logic [5:0] m);
    int h;
    h = 0;
    for (int i = 0; i < 6; i++) begin
      if (m[i]) h = i;
    end
    return h;
  endfunction

  localparam int DP_HI = dp_high(DP_MASK);
`endif

  // Active-low segment pattern for one BCD digit, decimal point off.
  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hc0;
      4'd1:    s = 8'hf9;
      4'd2:    s = 8'ha4;
      4'd3:    s = 8'hb0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hf8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hff;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, DECODE} state_t;

  state_t                     state_q, state_d;
  logic [BIN_W-1:0]           shift_q, shift_d;
  logic [BCD_W-1:0]           bcd_q, bcd_d;
  logic [ITER_W-1:0]          iter_q, iter_d;
  logic                       ovf_pend_q, ovf_pend_d;
  logic [NDIG-1:0][7:0]       seg_q, seg_d;
  logic                       done_q, done_d;
  logic                       overflow_q, overflow_d;
  logic                       ready_q, ready_d;

  // Add-3 step: nibbles 0..4 in full; only the low 3 bits of nibble 5 survive the shift.
  logic [19:0]                bcd_adj;
  logic [2:0]                 bcd_adj5;
  logic [NDIG-1:0][7:0]       seg_dec;
  logic [3:0]                 digit;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic                       lead;
`endif

  // Per-nibble add-3 correction, no carry between nibbles.
  always_comb begin
    bcd_adj  = '0;
    bcd_adj5 = '0;
    for (int i = 0; i < 5; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    bcd_adj5 = (bcd_q[23:20] >= 4'd5) ? bcd_q[22:20] + 3'd3 : bcd_q[22:20];
  end

  // Segment patterns for the finished BCD value, including dp, blanking and overflow dashes.
  always_comb begin
    seg_dec = '1;
    digit   = '0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    lead    = 1'b1;
`endif
    for (int i = int'(NDIG) - 1; i >= 0; i--) begin
      digit      = bcd_q[4*i +: 4];
      seg_dec[i] = seg_of(digit) & ~{DP_MASK[i], 7'b0};
`ifdef SEG_LEADING_ZERO_BLANK_EN
      lead = lead && (digit == 4'd0);
      if (lead && (i > DP_HI)) seg_dec[i] = 8'hff;
`endif
      if (ovf_pend_q) seg_dec[i] = 8'hbf;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    ovf_pend_d = ovf_pend_q;
    seg_d      = seg_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d    = CONV;
          shift_d    = bus.in_value;
          bcd_d      = '0;
          iter_d     = '0;
          ovf_pend_d = 32'(bus.in_value) > MAX_DISP;
        end
      end
      CONV: begin
        bcd_d   = {bcd_adj5, bcd_adj, shift_q[BIN_W-1]};
        shift_d = {shift_q[BIN_W-2:0], 1'b0};
        iter_d  = iter_q + ITER_W'(1);
        if (iter_q == ITER_W'(BIN_W - 1)) state_d = DECODE;
      end
      DECODE: begin
        seg_d      = seg_dec;
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      ovf_pend_q <= 1'b0;
      seg_q      <= '1;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      ovf_pend_q <= ovf_pend_d;
      seg_q      <= seg_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.done       = done_q;
  assign bus.overflow   = overflow_q;
  assign bus.seg_data_0 = seg_q[0];
  assign bus.seg_data_1 = seg_q[1];
  assign bus.seg_data_2 = seg_q[2];
  assign bus.seg_data_3 = seg_q[3];
  assign bus.seg_data_4 = seg_q[4];
  assign bus.seg_data_5 = seg_q[5];

endmodule

// File: tb/tb_seg_bin2bcd_encoder.sv
// Scoreboard bench for seg_bin2bcd_encoder: two instances (no dp, dp on digit 2)
// share one stimulus stream; a negedge monitor checks every done pulse.
module tb_seg_bin2bcd_encoder;

  localparam int unsigned BIN_W = 20;
  localparam int          NV    = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg_bin2bcd_encoder_if #(.BIN_W(BIN_W)) bus0 ();
  seg_bin2bcd_encoder_if #(.BIN_W(BIN_W)) bus1 ();

  assign bus1.in_valid = bus0.in_valid;
  assign bus1.in_value = bus0.in_value;

  seg_bin2bcd_encoder #(.BIN_W(BIN_W), .DP_MASK(6'b000000)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  seg_bin2bcd_encoder #(.BIN_W(BIN_W), .DP_MASK(6'b000100)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Hand-computed vectors, packed as {digit5 .. digit0}.
  int          vals [NV] = '{123456, 42, 0, 1048575, 999999, 1234, 5};
  logic        ovfs [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [47:0] e0 [NV] = '{48'hf9a4b0999282, 48'hffffffff99a4, 48'hffffffffffc0,
                           48'hbfbfbfbfbfbf, 48'h909090909090, 48'hfffff9a4b099,
                           48'hffffffffff92};
  logic [47:0] e1 [NV] = '{48'hf9a4b0199282, 48'hffffff4099a4, 48'hffffff40c0c0,
                           48'hbfbfbfbfbfbf, 48'h909090109090, 48'hfffff924b099,
                           48'hffffff40c092};
`else
  logic [47:0] e0 [NV] = '{48'hf9a4b0999282, 48'hc0c0c0c099a4, 48'hc0c0c0c0c0c0,
                           48'hbfbfbfbfbfbf, 48'h909090909090, 48'hc0c0f9a4b099,
                           48'hc0c0c0c0c092};
  logic [47:0] e1 [NV] = '{48'hf9a4b0199282, 48'hc0c0c04099a4, 48'hc0c0c040c0c0,
                           48'hbfbfbfbfbfbf, 48'h909090109090, 48'hc0c0f924b099,
                           48'hc0c0c040c092};
`endif

  typedef struct {
    logic [47:0] s0;
    logic [47:0] s1;
    logic        ovf;
    int          acc;
    int          val;
  } exp_t;

  exp_t q [$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic rst_chk  = 1'b0;
  logic drain_req = 1'b0;

  function automatic logic [47:0] segs(input logic [7:0] s5, s4, s3, s2, s1, s0);
    return {s5, s4, s3, s2, s1, s0};
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: sole owner of the check counters.
  always @(negedge clk) begin
    exp_t e;
    if (rst_chk) begin
      chk("rst_seg0", segs(bus0.seg_data_5, bus0.seg_data_4, bus0.seg_data_3,
                           bus0.seg_data_2, bus0.seg_data_1, bus0.seg_data_0), {6{8'hff}});
      chk("rst_seg1", segs(bus1.seg_data_5, bus1.seg_data_4, bus1.seg_data_3,
                           bus1.seg_data_2, bus1.seg_data_1, bus1.seg_data_0), {6{8'hff}});
      chk("rst_done", 48'({bus0.done, bus1.done}), 48'd0);
      chk("rst_ovf", 48'({bus0.overflow, bus1.overflow}), 48'd0);
      chk("rst_ready", 48'({bus0.in_ready, bus1.in_ready}), 48'd3);
    end
    if (drain_req) chk("queue_drained", 48'(q.size()), 48'd0);
    if (!rst && (bus0.done || bus1.done)) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 48'd1, 48'd0);
      end else begin
        e = q.pop_front();
        chk($sformatf("seg0_val%0d", e.val),
            segs(bus0.seg_data_5, bus0.seg_data_4, bus0.seg_data_3,
                 bus0.seg_data_2, bus0.seg_data_1, bus0.seg_data_0), e.s0);
        chk($sformatf("seg1_val%0d", e.val),
            segs(bus1.seg_data_5, bus1.seg_data_4, bus1.seg_data_3,
                 bus1.seg_data_2, bus1.seg_data_1, bus1.seg_data_0), e.s1);
        chk($sformatf("ovf_val%0d", e.val), 48'({bus0.overflow, bus1.overflow}),
            48'({e.ovf, e.ovf}));
        chk($sformatf("done_both_val%0d", e.val), 48'({bus0.done, bus1.done}), 48'd3);
        chk($sformatf("latency_val%0d", e.val), 48'(cyc - e.acc), 48'(BIN_W + 1));
      end
    end
  end

  // Present one value, wait (bounded) for acceptance, optionally record the expectation.
  task automatic send(input int idx, input bit push);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (!bus0.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus0.in_valid = 1'b1;
    bus0.in_value = 20'(vals[idx]);
    @(posedge clk);
    #1;
    if (push) begin
      e.s0  = e0[idx];
      e.s1  = e1[idx];
      e.ovf = ovfs[idx];
      e.acc = cyc;
      e.val = vals[idx];
      q.push_back(e);
    end
    bus0.in_valid = 1'b0;
  endtask

  task automatic pulse_rst_chk();
    @(posedge clk);
    #1 rst_chk = 1'b1;
    @(negedge clk);
    #1 rst_chk = 1'b0;
  endtask

  initial begin
    int guard;
    bus0.in_valid = 1'b0;
    bus0.in_value = '0;
    repeat (3) @(negedge clk);
    pulse_rst_chk();
    rst = 1'b0;
    pulse_rst_chk();

    send(0, 1'b1);
    send(1, 1'b1);
    // Keep offering new values while busy; none of them may be taken.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus0.in_valid = 1'b1;
      bus0.in_value = 20'(777 + k);
    end
    @(negedge clk);
    bus0.in_valid = 1'b0;
    for (int i = 2; i < NV; i++) send(i, 1'b1);

    // Abort a conversion with reset: no done pulse, reset outputs.
    send(0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    pulse_rst_chk();
    @(negedge clk);
    rst = 1'b0;
    pulse_rst_chk();
    repeat (30) @(negedge clk);

    send(5, 1'b1);
    send(0, 1'b1);

    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 drain_req = 1'b1;
    @(negedge clk);
    #1 drain_req = 1'b0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
